usb_rx_framer: RTL and testbench
================================

# usb_rx_framer

Receive-side line front end for the USB link. Samples the device's dp/dm lines one symbol per clock, locks onto SYNC, NRZI-decodes, strips stuffed bits, detects EOP and hands a framed serial bit stream to the inbound decode chain. It sits between the line pins and the CRC decoder, mirroring the transmit path's NRZI encoder, bit stuffer and line driver.

## Interface
Parameters:
- MAX_BITS, 99: largest legal payload bit count; more bits than this is an error.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  bit-rate clock, one line symbol per cycle
- rst_b  in  1  asynchronous active-low reset
- re  in  1  receive enable from protocol FSM; low aborts and holds IDLE
- dp_r  in  1  D+ line sample, already synchronized to clk
- dm_r  in  1  D- line sample, already synchronized to clk
- bit_out  out  1  decoded, unstuffed data bit
- bit_valid  out  1  bit_out is a payload bit this cycle
- pkt_start  out  1  one-cycle pulse: SYNC accepted
- pkt_end  out  1  one-cycle pulse: valid EOP received
- nbits  out  7  payload bits delivered in current/last packet; held after pkt_end
- rx_err  out  1  one-cycle pulse: packet aborted with error
- err_code  out  2  with rx_err: 01 stuff, 10 EOP, 11 SE1/overflow; held until next error
- busy  out  1  high in any state other than IDLE

## Operation
- Line symbols: J = (dp_r,dm_r)=(1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
- States: IDLE, SYNC, DATA, EOP, ERR_WAIT.
- IDLE: on K with re=1, count it as SYNC symbol 0 and go to SYNC.
- SYNC: symbols 1..7 must equal J,K,J,K,J,K,K. Any mismatch returns to IDLE silently (no pulse). After symbol 7, pulse pkt_start, clear nbits and ones counter, set prev level = K, go to DATA.
- DATA, J or K symbol: decoded bit = 1 if symbol equals prev level, else 0; prev level updated.
  - ones counter < 6: emit bit (bit_valid=1), nbits+1; ones counter +1 on 1, cleared on 0.
  - ones counter = 6: bit must be 0; it is dropped (no bit_valid), counter cleared. A 1 is a stuff error (code 01).
  - Emitting bit number MAX_BITS+1 is an overflow error (code 11); that bit is not emitted.
- DATA, SE0: go to EOP, SE0 count = 1. DATA, SE1: error code 11.
- EOP: second SE0 -> count 2, stay. J with count = 2 -> pulse pkt_end, go IDLE. J with count = 1, third SE0, K or SE1 -> error code 10 (SE1 gives 11).
- Any error: pulse rx_err, set err_code, go ERR_WAIT. bit_valid never asserts after an error.
- ERR_WAIT: wait for SE0 followed by J (line idle after EOP), then IDLE.
- re low in any state: next state IDLE, no pkt_end, no rx_err; nbits and err_code hold.
- Priority in one cycle: re low > SE1 > other checks.

## Timing
- All outputs registered; each reflects the symbol sampled on the previous clock edge.
- Reset values: bit_out 0, bit_valid 0, pkt_start 0, pkt_end 0, nbits 0, rx_err 0, err_code 00, busy 0; state IDLE, ones counter 0, prev level K.
- pkt_start high the cycle after SYNC symbol 7 is sampled; first bit_valid at earliest the following cycle.
- Latency symbol-to-bit_valid: 1 cycle. Stuffed bit produces a 1-cycle bit_valid gap.
- pkt_end high the cycle after the J that follows two SE0s; nbits is final in that same cycle.
- rx_err high the cycle after the offending symbol.
- pkt_start, pkt_end, rx_err, bit_valid are mutually exclusive in any cycle.
- nbits saturates at MAX_BITS (never wraps).
- Reset mid-packet: immediate IDLE, all outputs to reset values, no pulses.

## Test plan
- SYNC (K J K J K J K K), then K J K K, SE0 SE0 J -> pkt_start, bit_out 1,0,0,1 on 4 consecutive bit_valid cycles, pkt_end with nbits=4, no rx_err.
- SYNC, then K×6 J K, SE0 SE0 J -> six 1s, stuffed 0 dropped (one gap), then 0, nbits=7, pkt_end.
- SYNC, then K×7 -> rx_err err_code=01 one cycle after 7th K, no pkt_end; then SE0 J -> busy falls, next SYNC accepted.
- Corrupt SYNC K J K K ... -> no pkt_start, busy low again, subsequent good packet received normally.
- SYNC, 2 data bits, SE0 J -> rx_err err_code=10; separately, SE1 mid-data -> err_code=11; 100 data bits -> err_code=11, nbits=99.
- Drop re, and separately pulse rst_b low, mid-DATA -> IDLE next cycle, no pkt_end/rx_err; all outputs at reset values after reset.

Source files
------------

// File: rtl/usb_rx_framer.sv
// USB receive line front end: SYNC lock, NRZI decode, bit unstuffing and EOP detection.
// Emits one decoded payload bit per cycle with packet start/end/error pulses.
module usb_rx_framer #(
  parameter int unsigned MAX_BITS = 99
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       re,
  input  logic       dp_r,
  input  logic       dm_r,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic [6:0] nbits,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [6:0] MaxBits = 7'(MAX_BITS);

  typedef enum logic [2:0] {StIdle, StSync, StData, StEop, StErrWait} state_e;

  state_e     state_q;
  logic [2:0] sync_cnt_q;
  logic [2:0] ones_q;
  logic       prev_j_q;
  logic       se0_two_q;
  logic       seen_se0_q;

  logic sym_j, sym_k, sym_se0, sym_se1;
  logic dec_bit;
  logic sync_ok;
  logic err_now;
  logic [1:0] err_val;

  assign sym_j   = dp_r & ~dm_r;
  assign sym_k   = ~dp_r & dm_r;
  assign sym_se0 = ~dp_r & ~dm_r;
  assign sym_se1 = dp_r & dm_r;

  // NRZI: no transition on the line means a 1.
  assign dec_bit = (sym_j == prev_j_q);

  // SYNC symbols 1..7 are J,K,J,K,J,K,K: odd indices below 7 expect J.
  assign sync_ok = (sync_cnt_q[0] && (sync_cnt_q != 3'd7)) ? sym_j : sym_k;

  assign busy = (state_q != StIdle);

  always_comb begin
    err_now = 1'b0;
    err_val = 2'b00;
    if (re) begin
      case (state_q)
        StData: begin
          if (sym_se1) begin
            err_now = 1'b1;
            err_val = 2'b11;
          end else if (!sym_se0 && (ones_q == 3'd6) && dec_bit) begin
            err_now = 1'b1;
            err_val = 2'b01;
          end else if (!sym_se0 && (ones_q != 3'd6) && (nbits == MaxBits)) begin
            err_now = 1'b1;
            err_val = 2'b11;
          end
        end
        StEop: begin
          if (sym_se1) begin
            err_now = 1'b1;
            err_val = 2'b11;
          end else if (!((sym_se0 && !se0_two_q) || (sym_j && se0_two_q))) begin
            err_now = 1'b1;
            err_val = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      sync_cnt_q <= 3'd0;
      ones_q     <= 3'd0;
      prev_j_q   <= 1'b0;
      se0_two_q  <= 1'b0;
      seen_se0_q <= 1'b0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      pkt_start  <= 1'b0;
      pkt_end    <= 1'b0;
      nbits      <= 7'd0;
      rx_err     <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      bit_valid <= 1'b0;
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      rx_err    <= 1'b0;
      if (!re) begin
        state_q <= StIdle;
      end else if (err_now) begin
        rx_err     <= 1'b1;
        err_code   <= err_val;
        seen_se0_q <= 1'b0;
        state_q    <= StErrWait;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (sym_k) begin
              sync_cnt_q <= 3'd1;
              state_q    <= StSync;
            end
          end
          StSync: begin
            if (!sync_ok) begin
              state_q <= StIdle;
            end else if (sync_cnt_q == 3'd7) begin
              pkt_start <= 1'b1;
              nbits     <= 7'd0;
              ones_q    <= 3'd0;
              prev_j_q  <= 1'b0;
              state_q   <= StData;
            end else begin
              sync_cnt_q <= sync_cnt_q + 3'd1;
            end
          end
          StData: begin
            if (sym_se0) begin
              se0_two_q <= 1'b0;
              state_q   <= StEop;
            end else if (ones_q == 3'd6) begin
              // Stuffed zero: track the level but drop the bit.
              prev_j_q <= sym_j;
              ones_q   <= 3'd0;
            end else begin
              prev_j_q  <= sym_j;
              bit_out   <= dec_bit;
              bit_valid <= 1'b1;
              nbits     <= nbits + 7'd1;
              ones_q    <= dec_bit ? ones_q + 3'd1 : 3'd0;
            end
          end
          StEop: begin
            if (sym_se0) begin
              se0_two_q <= 1'b1;
            end else begin
              pkt_end <= 1'b1;
              state_q <= StIdle;
            end
          end
          StErrWait: begin
            if (sym_se0) begin
              seen_se0_q <= 1'b1;
            end else if (sym_j && seen_se0_q) begin
              state_q <= StIdle;
            end else if (!sym_j) begin
              seen_se0_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_framer.sv
// Self-checking bench for usb_rx_framer: expected output events are queued as symbols
// are driven and matched in order against what the framer emits.
module tb_usb_rx_framer;

  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;
  localparam logic [1:0] EvBit = 2'd0, EvStart = 2'd1, EvEnd = 2'd2, EvErr = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [6:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_b, re, dp_r, dm_r;
  logic       bit_out, bit_valid, pkt_start, pkt_end, rx_err, busy;
  logic [6:0] nbits;
  logic [1:0] err_code;

  ev_t exp_q[$];
  ev_t mon_obs, mon_exp;
  int  mon_n;
  int  checks = 0;
  int  errors = 0;

  usb_rx_framer #(.MAX_BITS(99)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .re       (re),
    .dp_r     (dp_r),
    .dm_r     (dm_r),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .pkt_start(pkt_start),
    .pkt_end  (pkt_end),
    .nbits    (nbits),
    .rx_err   (rx_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Output monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_b === 1'b1) begin
      mon_n = int'(bit_valid) + int'(pkt_start) + int'(pkt_end) + int'(rx_err);
      if (mon_n != 0) begin
        checks++;
        if (mon_n > 1) begin
          errors++;
          $display("FAIL exclusive_pulses: got valid=%0b start=%0b end=%0b err=%0b, required one",
                   bit_valid, pkt_start, pkt_end, rx_err);
        end else begin
          if (bit_valid)      mon_obs = ev_t'({EvBit, 6'd0, bit_out});
          else if (pkt_start) mon_obs = ev_t'({EvStart, nbits});
          else if (pkt_end)   mon_obs = ev_t'({EvEnd, nbits});
          else                mon_obs = ev_t'({EvErr, 5'd0, err_code});
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d, required none",
                     mon_obs.kind, mon_obs.val);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_obs !== mon_exp) begin
              errors++;
              $display("FAIL event: got kind=%0d val=%0d, required kind=%0d val=%0d",
                       mon_obs.kind, mon_obs.val, mon_exp.kind, mon_exp.val);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [1:0] kind, input logic [6:0] val);
    exp_q.push_back(ev_t'({kind, val}));
  endtask

  task automatic send(input logic [1:0] s);
    @(posedge clk);
    #1;
    {dp_r, dm_r} = s;
  endtask

  task automatic send_sync;
    logic [1:0] seq [8];
    seq = '{K, J, K, J, K, J, K, K};
    push(EvStart, 7'd0);
    for (int i = 0; i < 8; i++) send(seq[i]);
  endtask

  task automatic send_eop;
    send(SE0);
    send(SE0);
    send(J);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(J);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    re    = 1'b1;
    {dp_r, dm_r} = J;
    #23;
    checks++;
    if ({bit_out, bit_valid, pkt_start, pkt_end, nbits, rx_err, err_code, busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {bit_out, bit_valid, pkt_start, pkt_end, nbits, rx_err, err_code, busy});
    end
    @(negedge clk);
    rst_b = 1'b1;
    idle(3);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_basic;
    send_sync();
    push(EvBit, 7'd1); push(EvBit, 7'd0); push(EvBit, 7'd0); push(EvBit, 7'd1);
    push(EvEnd, 7'd4);
    send(K); send(J); send(K); send(K);
    send_eop();
    drain("basic");
    checks++;
    if (nbits !== 7'd4) begin
      errors++;
      $display("FAIL basic_nbits_held: got %0d, required 4", nbits);
    end
    idle(2);
  endtask

  task automatic test_stuff;
    send_sync();
    for (int i = 0; i < 6; i++) push(EvBit, 7'd1);
    push(EvBit, 7'd0);
    push(EvEnd, 7'd7);
    for (int i = 0; i < 6; i++) send(K);
    send(J);
    send(K);
    send_eop();
    drain("stuff");
    idle(2);
  endtask

  task automatic test_stuff_err;
    send_sync();
    for (int i = 0; i < 6; i++) push(EvBit, 7'd1);
    push(EvErr, 7'd1);
    for (int i = 0; i < 7; i++) send(K);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rx_err, err_code, busy} !== 4'b1011) begin
      errors++;
      $display("FAIL stuff_err_timing: got rx_err/code/busy=%b, required 1011",
               {rx_err, err_code, busy});
    end
    send(SE0);
    send(J);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, err_code} !== 3'b001) begin
      errors++;
      $display("FAIL stuff_err_recover: got busy/code=%b, required 001", {busy, err_code});
    end
    drain("stuff_err");
    send_sync();
    push(EvBit, 7'd1);
    push(EvEnd, 7'd1);
    send(K);
    send_eop();
    drain("after_stuff_err");
    idle(2);
  endtask

  task automatic test_bad_sync;
    send(K); send(J); send(K); send(K);
    idle(3);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_sync_busy: got %b, required 0", busy);
    end
    drain("bad_sync");
    send_sync();
    push(EvBit, 7'd0); push(EvBit, 7'd1);
    push(EvEnd, 7'd2);
    send(J); send(J);
    send_eop();
    drain("after_bad_sync");
    idle(2);
  endtask

  task automatic test_eop_err;
    send_sync();
    push(EvBit, 7'd1); push(EvBit, 7'd0);
    push(EvErr, 7'd2);
    send(K); send(J);
    send(SE0); send(J);
    send(SE0); send(J);
    idle(2);
    drain("eop_err");
    checks++;
    if ({busy, err_code} !== 3'b010) begin
      errors++;
      $display("FAIL eop_err_state: got busy/code=%b, required 010", {busy, err_code});
    end
  endtask

  task automatic test_se1;
    send_sync();
    push(EvBit, 7'd1);
    push(EvErr, 7'd3);
    send(K); send(SE1);
    send(SE0); send(J);
    idle(2);
    drain("se1");
    checks++;
    if ({busy, err_code} !== 3'b011) begin
      errors++;
      $display("FAIL se1_state: got busy/code=%b, required 011", {busy, err_code});
    end
  endtask

  task automatic test_overflow;
    send_sync();
    for (int i = 0; i < 99; i++) push(EvBit, 7'd0);
    push(EvErr, 7'd3);
    for (int i = 0; i < 100; i++) send((i % 2 == 0) ? J : K);
    send(SE0); send(J);
    idle(2);
    drain("overflow");
    checks++;
    if ({nbits, err_code, busy} !== {7'd99, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL overflow_state: got nbits=%0d code=%b busy=%b, required nbits=99 code=11 busy=0",
               nbits, err_code, busy);
    end
  endtask

  task automatic test_re_abort;
    send_sync();
    push(EvBit, 7'd1); push(EvBit, 7'd0);
    send(K); send(J);
    @(posedge clk);
    #1;
    re = 1'b0;
    {dp_r, dm_r} = K;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, nbits, err_code} !== {1'b0, 7'd2, 2'b11}) begin
      errors++;
      $display("FAIL re_abort_state: got busy=%b nbits=%0d code=%b, required busy=0 nbits=2 code=11",
               busy, nbits, err_code);
    end
    send(SE0); send(SE0); send(J); send(J);
    drain("re_abort");
    re = 1'b1;
    idle(2);
  endtask

  task automatic test_rst_abort;
    send_sync();
    push(EvBit, 7'd1);
    send(K); send(J);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    checks++;
    if ({bit_out, bit_valid, pkt_start, pkt_end, nbits, rx_err, err_code, busy} !== 14'd0) begin
      errors++;
      $display("FAIL rst_abort_outputs: got %b, required all zero",
               {bit_out, bit_valid, pkt_start, pkt_end, nbits, rx_err, err_code, busy});
    end
    {dp_r, dm_r} = J;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    idle(3);
    drain("rst_abort");
    checks++;
    if ({nbits, err_code, busy} !== 10'd0) begin
      errors++;
      $display("FAIL rst_abort_idle: got nbits=%0d code=%b busy=%b, required all zero",
               nbits, err_code, busy);
    end
  endtask

  task automatic test_back_to_back;
    send_sync();
    push(EvBit, 7'd0); push(EvBit, 7'd1);
    push(EvEnd, 7'd2);
    send(J); send(J);
    send_eop();
    send_sync();
    push(EvBit, 7'd1);
    push(EvEnd, 7'd1);
    send(K);
    send_eop();
    drain("back_to_back");
    checks++;
    if ({nbits, busy} !== {7'd1, 1'b0}) begin
      errors++;
      $display("FAIL back_to_back_state: got nbits=%0d busy=%b, required nbits=1 busy=0",
               nbits, busy);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuff();
    test_stuff_err();
    test_bad_sync();
    test_eop_err();
    test_se1();
    test_overflow();
    test_re_abort();
    test_rst_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
